// File: rtl/hit_scorer_if.sv
// Signal bundle between the light/keypad controllers, the hit judge and the top-level FSM.
interface hit_scorer_if #(
  parameter int CNT_W   = 6,
  parameter int LIVES_W = 2
);
  logic               enable;
  logic               use_lives;
  logic               light_on;
  logic [3:0]         light_pos;
  logic               key_valid;
  logic [3:0]         key;
  logic [CNT_W-1:0]   score;
  logic [CNT_W-1:0]   misses;
  logic [CNT_W-1:0]   wrong;
  logic [LIVES_W-1:0] lives_left;
  logic               hit_pulse;
  logic               out_of_lives;

  modport master (
    output enable, use_lives, light_on, light_pos, key_valid, key,
    input  score, misses, wrong, lives_left, hit_pulse, out_of_lives
  );

  modport slave (
    input  enable, use_lives, light_on, light_pos, key_valid, key,
    output score, misses, wrong, lives_left, hit_pulse, out_of_lives
  );
endinterface

// File: rtl/hit_scorer.sv
// Clocked whack-a-mole judge: scores at most one hit per lit light and tracks
// misses, wrong presses and lives, raising a sticky out-of-lives flag.
module hit_scorer #(
  parameter int CNT_W   = 6,
  parameter int LIVES   = 3,
  parameter int LIVES_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  hit_scorer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    JUDGED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  state_t             state_q, state_d;
  logic [3:0]         pos_q, pos_d;
  logic [CNT_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]   misses_q, misses_d;
  logic [CNT_W-1:0]   wrong_q, wrong_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               ool_q, ool_d;

  logic inc_score, inc_miss, inc_wrong, penalty;
  logic count_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      wrong_q     <= '0;
      lives_q     <= LIVES_INIT;
      hit_pulse_q <= 1'b0;
      ool_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      wrong_q     <= wrong_d;
      lives_q     <= lives_d;
      hit_pulse_q <= hit_pulse_d;
      ool_q       <= ool_d;
    end
  end

  // Judge: decide which events happened this cycle and where the light stands.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    inc_score = 1'b0;
    inc_miss  = 1'b0;
    inc_wrong = 1'b0;
    penalty   = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.key_valid) begin
            inc_wrong = 1'b1;
            penalty   = 1'b1;
          end
          if (bus.light_on) begin
            state_d = ARMED;
            pos_d   = bus.light_pos;
          end
        end
        ARMED: begin
          if (bus.key_valid && bus.key == pos_q) begin
            // A matching key wins over an expiring or replaced light; any new
            // light is picked up from JUDGED on the following cycle.
            inc_score = 1'b1;
            state_d   = JUDGED;
          end else begin
            if (bus.key_valid) begin
              inc_wrong = 1'b1;
              penalty   = 1'b1;
            end
            if (!bus.light_on) begin
              inc_miss = 1'b1;
              penalty  = 1'b1;
              state_d  = IDLE;
            end else if (bus.light_pos != pos_q) begin
              inc_miss = 1'b1;
              penalty  = 1'b1;
              pos_d    = bus.light_pos;
            end
          end
        end
        JUDGED: begin
          if (bus.key_valid) begin
            inc_wrong = 1'b1;
          end
          if (!bus.light_on) begin
            state_d = IDLE;
          end else if (bus.light_pos != pos_q) begin
            state_d = ARMED;
            pos_d   = bus.light_pos;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_en = bus.enable && !ool_q;

  always_comb begin
    score_d     = score_q;
    misses_d    = misses_q;
    wrong_d     = wrong_q;
    lives_d     = lives_q;
    ool_d       = ool_q;
    hit_pulse_d = 1'b0;

    if (count_en) begin
      if (inc_score && score_q != CNT_MAX) score_d = score_q + 1'b1;
      if (inc_miss && misses_q != CNT_MAX) misses_d = misses_q + 1'b1;
      if (inc_wrong && wrong_q != CNT_MAX) wrong_d = wrong_q + 1'b1;
      hit_pulse_d = inc_score;
      // Coincident penalties cost a single life.
      if (bus.use_lives && penalty && lives_q != '0) begin
        lives_d = lives_q - 1'b1;
        if (lives_q == LIVES_W'(1)) ool_d = 1'b1;
      end
    end
  end

  assign bus.score        = score_q;
  assign bus.misses       = misses_q;
  assign bus.wrong        = wrong_q;
  assign bus.lives_left   = lives_q;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.out_of_lives = ool_q;

endmodule

// File: tb/tb_hit_scorer.sv
// Directed bench for hit_scorer: each step drives inputs, clocks once and
// checks the registered outputs against hand-computed values.
module tb_hit_scorer;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  hit_scorer_if #(.CNT_W(6), .LIVES_W(2)) bus ();

  hit_scorer #(.CNT_W(6), .LIVES(3), .LIVES_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input int s, input int m, input int w,
                           input int l, input int h, input int o);
    check({tag, ".score"},  int'(bus.score), s);
    check({tag, ".misses"}, int'(bus.misses), m);
    check({tag, ".wrong"},  int'(bus.wrong), w);
    check({tag, ".lives"},  int'(bus.lives_left), l);
    check({tag, ".hit"},    int'(bus.hit_pulse), h);
    check({tag, ".ool"},    int'(bus.out_of_lives), o);
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    reset              = 1'b0;
    bus.enable    = 1'b0;
    bus.use_lives = 1'b0;
    bus.light_on  = 1'b0;
    bus.light_pos = 4'd0;
    bus.key_valid = 1'b0;
    bus.key       = 4'd0;

    #12;
    check_all("reset", 0, 0, 0, 3, 0, 0);
    reset = 1'b1;
    tick();

    // Basic hit on light 4
    bus.enable = 1'b1; bus.light_on = 1'b1; bus.light_pos = 4'd4;
    tick();
    bus.key_valid = 1'b1; bus.key = 4'd4;
    tick();
    check_all("hit4", 1, 0, 0, 3, 1, 0);
    bus.key_valid = 1'b0;
    tick();
    check("hit4.pulse_drop", int'(bus.hit_pulse), 0);

    // Double tap on a judged light: wrong, no life lost even in lives mode
    bus.use_lives = 1'b1; bus.key_valid = 1'b1; bus.key = 4'd4;
    tick();
    check_all("double_tap", 1, 0, 1, 3, 0, 0);
    bus.key_valid = 1'b0; bus.light_on = 1'b0;
    tick();

    // Three expired lights in lives mode
    for (int i = 1; i <= 3; i++) begin
      bus.light_on = 1'b1; bus.light_pos = 4'd2;
      tick();
      bus.light_on = 1'b0;
      tick();
      check($sformatf("expire%0d.misses", i), int'(bus.misses), i);
      check($sformatf("expire%0d.lives", i), int'(bus.lives_left), 3 - i);
      check($sformatf("expire%0d.ool", i), int'(bus.out_of_lives), (i == 3) ? 1 : 0);
    end

    // Frozen after out of lives
    bus.light_on = 1'b1; bus.light_pos = 4'd3;
    tick();
    bus.key_valid = 1'b1; bus.key = 4'd5;
    tick();
    bus.key_valid = 1'b1; bus.key = 4'd3;
    tick();
    bus.key_valid = 1'b0; bus.light_on = 1'b0;
    tick();
    check_all("frozen", 1, 3, 1, 0, 0, 1);

    // Asynchronous reset, checked before any further clock edge
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 3, 0, 0);
    bus.use_lives = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Matching key in the same cycle the light goes out
    bus.light_on = 1'b1; bus.light_pos = 4'd7;
    tick();
    bus.light_on = 1'b0; bus.key_valid = 1'b1; bus.key = 4'd7;
    tick();
    check_all("fall_hit", 1, 0, 0, 3, 1, 0);
    bus.key_valid = 1'b0;
    tick();

    // Back-to-back lights 1 then 5, no key for 1
    bus.light_on = 1'b1; bus.light_pos = 4'd1;
    tick();
    bus.light_pos = 4'd5;
    tick();
    check("b2b.misses", int'(bus.misses), 1);
    bus.key_valid = 1'b1; bus.key = 4'd5;
    tick();
    check_all("b2b_hit", 2, 1, 0, 3, 1, 0);
    bus.key_valid = 1'b0;

    // 64 more hits saturate the score at 63
    for (int i = 0; i < 64; i++) begin
      bus.light_pos = (i % 2 == 0) ? 4'd3 : 4'd6;
      bus.key_valid = 1'b0;
      tick();
      bus.key_valid = 1'b1; bus.key = bus.light_pos;
      tick();
    end
    bus.key_valid = 1'b0;
    tick();
    check_all("saturate", 63, 1, 0, 3, 0, 0);

    // Async reset while ARMED on light 8
    bus.light_pos = 4'd8;
    tick();
    #2;
    reset = 1'b0; bus.enable = 1'b0;
    #1;
    check_all("rst_armed", 0, 0, 0, 3, 0, 0);
    tick();
    reset = 1'b1;

    // Disabled: key presses ignored
    bus.key_valid = 1'b1; bus.key = 4'd8;
    tick();
    tick();
    check_all("disabled", 0, 0, 0, 3, 0, 0);

    // Light still on after reset is armed once enabled
    bus.key_valid = 1'b0; bus.enable = 1'b1;
    tick();
    bus.key_valid = 1'b1; bus.key = 4'd8;
    tick();
    check_all("rearm", 1, 0, 0, 3, 1, 0);
    bus.key_valid = 1'b0; bus.light_on = 1'b0;
    tick();

    // Wrong key plus expiry in one cycle: one life lost
    bus.use_lives = 1'b1; bus.light_on = 1'b1; bus.light_pos = 4'd2;
    tick();
    bus.light_on = 1'b0; bus.key_valid = 1'b1; bus.key = 4'd4;
    tick();
    check_all("dual_pen", 1, 1, 1, 2, 0, 0);

    // Key with no light pending
    bus.key_valid = 1'b1; bus.key = 4'd0;
    tick();
    check_all("idle_key", 1, 1, 2, 1, 0, 0);
    bus.key_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
